act_stream_ctrl: RTL

ACT_STREAM_CTRL -- requirements
Module: act_stream_ctrl

---
 rtl/act_pkg.sv | 23 ++
 rtl/act_valid_pipe.sv | 62 ++++++
 rtl/act_stream_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/act_pkg.sv
// act_pkg: shared default widths and the controller state type for
// act_stream_ctrl and its delay line.
package act_pkg;

  // Default signed activation sample width.
  localparam int DATA_W = 8;

  // Default buffer address width. Jobs may cover up to 2**ADDR_W elements.
  localparam int ADDR_W = 8;

  // Job sequencing states.
  //   IDLE  : waiting for start
  //   RUN   : issuing one buffer read per cycle
  //   DRAIN : reads finished, waiting for the last result to be written
  //   DONE  : one-cycle completion pulse
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/act_valid_pipe.sv
// act_valid_pipe: fixed-depth delay line that follows each buffer read
// through the activation unit to its output-buffer write.
//
// Stage 0 is loaded in the cycle after the read is issued, carrying the
// valid flag and the read address. The sample itself only shows up on
// in_x one cycle after the read (buffer read latency), so the sample
// chain starts one stage later and is one entry shorter. A flush clears
// every valid at once and leaves the data stages alone.
module act_valid_pipe #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_x,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_x,
  output logic              pending
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] x_q    [DEPTH-1];

  // Shift the valid flags; a flush empties the whole line.
  // NOTE: clocked state uses non-blocking assignments so every stage
  // samples its neighbour's old value and the shift order does not matter.
  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q <= '0;
    end else begin
      valid_q <= {valid_q[DEPTH-2:0], in_valid};
    end
  end

  // Shift the address and sample payloads alongside the valids.
  // NOTE: payload stages are never reset; nothing downstream looks at
  // them unless the matching valid is set, so a reset would only add
  // wiring to a plain shift register.
  always_ff @(posedge clk) begin
    addr_q[0] <= in_addr;
    for (int i = 1; i < DEPTH; i++) begin
      addr_q[i] <= addr_q[i-1];
    end
    x_q[0] <= in_x;
    for (int i = 1; i < DEPTH - 1; i++) begin
      x_q[i] <= x_q[i-1];
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];
  assign out_x     = x_q[DEPTH-2];

  // Something is still in flight ahead of the output stage.
  assign pending = |valid_q[DEPTH-2:0];

endmodule

// File: rtl/act_stream_ctrl.sv
// act_stream_ctrl: streams a block of activation samples from an input
// buffer through a shared activation unit into an output buffer, one
// element per cycle with no bubbles.
//
// A job reads length elements starting at base_addr (addresses wrap at
// 2**ADDR_W). Each result is written to the address it was read from,
// exactly 1+ACT_LAT cycles after its read. abort or reset drops the job
// and everything in flight.
//
// Optional feature, macro ACT_BYPASS_EN: when defined, a job started with
// bypass=1 writes the raw samples instead of the activation results.
// When undefined, bypass is accepted but has no effect.
module act_stream_ctrl #(
  parameter int DATA_W  = act_pkg::DATA_W,
  parameter int ADDR_W  = act_pkg::ADDR_W,
  parameter int ACT_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              bypass,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] act_x,
  input  logic [DATA_W-1:0] act_y,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  import act_pkg::*;

  // Read issue to write: one cycle of buffer latency plus the unit latency.
  localparam int DEPTH = 1 + ACT_LAT;

  state_t            state;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx_q;     // number of reads issued so far
  logic              bypass_q;

  logic              pipe_valid;
  logic              pipe_pending;
  logic [ADDR_W-1:0] pipe_addr;
  logic [DATA_W-1:0] pipe_x;
  logic [DATA_W-1:0] wr_sel;

  // The sample returned by the buffer goes straight to the activation unit.
  assign act_x = rd_data;

  // Job sequencer: latches the job, issues reads, waits out the pipeline.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state   <= ST_IDLE;
      rd_en_q <= 1'b0;
      idx_q   <= '0;
      if (reset) begin
        rd_addr_q <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            len_q    <= length;
            bypass_q <= bypass;
            if (length == '0) begin
              state <= ST_DONE;
            end else begin
              state     <= ST_RUN;
              rd_en_q   <= 1'b1;
              rd_addr_q <= base_addr;
              idx_q     <= (ADDR_W+1)'(1);
            end
          end
        end
        ST_RUN: begin
          if (idx_q == len_q) begin
            rd_en_q <= 1'b0;
            state   <= ST_DRAIN;
          end else begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= base_q + idx_q[ADDR_W-1:0];
            idx_q     <= idx_q + (ADDR_W+1)'(1);
          end
        end
        ST_DRAIN: begin
          // Leave once only the output stage is occupied: that is the last write.
          if (!pipe_pending) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  act_valid_pipe #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_pipe (
    .clk       (clk),
    .clear     (reset | abort),
    .in_valid  (rd_en_q),
    .in_addr   (rd_addr_q),
    .in_x      (act_x),
    .out_valid (pipe_valid),
    .out_addr  (pipe_addr),
    .out_x     (pipe_x),
    .pending   (pipe_pending)
  );

`ifdef ACT_BYPASS_EN
  // Bypassed jobs write the delayed raw sample instead of the unit result.
  assign wr_sel = bypass_q ? pipe_x : act_y;
`else
  assign wr_sel = act_y;
  logic unused_bypass;
  assign unused_bypass = ^{bypass, bypass_q, pipe_x};
`endif

  // Output decode; reset forces every strobe low and every bus to zero.
  // NOTE: each output gets a value on every path through this block, so
  // it stays purely combinational instead of holding a stale value.
  always_comb begin
    rd_en   = rd_en_q & ~reset;
    rd_addr = reset ? '0 : rd_addr_q;
    wr_en   = pipe_valid & ~reset;
    wr_addr = wr_en ? pipe_addr : '0;
    wr_data = wr_en ? wr_sel : '0;
    busy    = ~reset & ((state == ST_RUN) || (state == ST_DRAIN));
    done    = ~reset & (state == ST_DONE);
  end

endmodule
